fifo_drain_ctrl: RTL

FIFO_DRAIN_CTRL -- requirements
Module: fifo_drain_ctrl

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/fifo_drain_ctrl_if.sv | 25 ++
 rtl/fifo_skid2.sv | 60 ++++++
 rtl/fifo_drain_ctrl.sv | 84 ++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO drain controller: data width, FIFO depth,
// drain FSM encoding and a counter-width helper.
package fifo_pkg;

    localparam int unsigned FIFO_WIDTH = 16;
    localparam int unsigned FIFO_DEPTH = 16;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = S_IDLE,
        RUN   = S_RUN,
        DRAIN = S_DRAIN
    } drain_state_e;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_drain_ctrl_if.sv
// FIFO read side and output stream of the drain controller, bundled together.
interface fifo_drain_ctrl_if #(
    parameter int unsigned W = fifo_pkg::FIFO_WIDTH
);

    logic         fifo_rd_en;
    logic [W-1:0] fifo_data_out;
    logic         fifo_empty;
    logic         fifo_underflow;
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_ready;
    logic         m_last;

    modport master (
        output fifo_rd_en, m_data, m_valid, m_last,
        input  fifo_data_out, fifo_empty, fifo_underflow, m_ready
    );

    modport slave (
        input  fifo_rd_en, m_data, m_valid, m_last,
        output fifo_data_out, fifo_empty, fifo_underflow, m_ready
    );

endinterface

// File: rtl/fifo_skid2.sv
// Two-entry in-order skid buffer; entry 0 is always the oldest word.
module fifo_skid2 #(
    parameter int unsigned W = fifo_pkg::FIFO_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);

    logic [W-1:0] ent0_q, ent0_d;
    logic [W-1:0] ent1_q, ent1_d;
    logic [1:0]   count_q, count_d;

    always_comb begin
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        count_d = count_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) ent0_d = din;
                else                 ent1_d = din;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                ent0_d  = ent1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // simultaneous push/pop: shift when full, else replace the head
                if (count_q == 2'd2) begin
                    ent0_d = ent1_q;
                    ent1_d = din;
                end else begin
                    ent0_d = din;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_q  <= '0;
            ent1_q  <= '0;
            count_q <= '0;
        end else begin
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            count_q <= count_d;
        end
    end

    assign dout  = ent0_q;
    assign count = count_q;

endmodule

// File: rtl/fifo_drain_ctrl.sv
// FIFO drain controller: fetches words from a FIFO into a skid buffer and
// streams them out with valid/ready, marking frame boundaries with m_last.
module fifo_drain_ctrl #(
    parameter int unsigned FIFO_WIDTH = fifo_pkg::FIFO_WIDTH,
    parameter int unsigned FRAME_LEN  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    fifo_drain_ctrl_if.master bus,
    output logic              busy,
    output logic              err_underflow
);

    import fifo_pkg::*;

    localparam int unsigned   CW        = cnt_width(FRAME_LEN);
    localparam logic [CW-1:0] LAST_BEAT = CW'(FRAME_LEN - 1);

    drain_state_e          state_q, state_d;
    logic                  in_flight_q, in_flight_d;
    logic                  err_q, err_d;
    logic [CW-1:0]         beat_q, beat_d;
    logic                  push, pop, last;
    logic [1:0]            count;
    logic [2:0]            outstanding;
    logic [FIFO_WIDTH-1:0] dout;

    fifo_skid2 #(.W(FIFO_WIDTH)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (bus.fifo_data_out),
        .dout  (dout),
        .count (count)
    );

    always_comb begin
        pop  = (count != 2'd0) && bus.m_ready;
        push = in_flight_q && !bus.fifo_underflow;
        last = (count != 2'd0) && (beat_q == LAST_BEAT);
        // words still held or returning once this cycle's pop has left
        outstanding = {1'b0, count} + {2'b00, in_flight_q} - {2'b00, pop};
        in_flight_d = (state_q == RUN) && !bus.fifo_empty && (outstanding < 3'd2);
        err_d = err_q || (in_flight_q && bus.fifo_underflow);

        beat_d = beat_q;
        if (pop) beat_d = last ? '0 : beat_q + CW'(1);

        state_d = state_q;
        case (state_q)
            IDLE:    if (en) state_d = RUN;
            RUN:     if (!en) state_d = DRAIN;
            DRAIN: begin
                if (en)                                     state_d = RUN;
                else if ((count == 2'd0) && !in_flight_q)   state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_flight_q <= 1'b0;
            err_q       <= 1'b0;
            beat_q      <= '0;
        end else begin
            state_q     <= state_d;
            in_flight_q <= in_flight_d;
            err_q       <= err_d;
            beat_q      <= beat_d;
        end
    end

    assign bus.fifo_rd_en = in_flight_d;
    assign bus.m_data     = dout;
    assign bus.m_valid    = (count != 2'd0);
    assign bus.m_last     = last;
    assign busy           = (state_q != IDLE);
    assign err_underflow  = err_q;

endmodule
